line_buffer_ctrl: RTL and testbench



---
 rtl/line_buffer_ctrl_if.sv | 50 +++++
 rtl/line_buffer_ctrl.sv | 174 +++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_ctrl_if.sv
// Handshake and line-buffer bus bundle for line_buffer_ctrl.
// The master side is the controller; the slave side is the pixel source,
// the two line buffers and the downstream window shifter.
interface line_buffer_ctrl_if #(
  parameter int unsigned D_WIDTH            = 16,
  parameter int unsigned LINE_BUF_ADDR_BITS = 5
) ();

  logic                          start;
  logic                          busy;
  logic                          in_valid;
  logic [D_WIDTH-1:0]            in_data;
  logic                          in_ready;
  logic [LINE_BUF_ADDR_BITS-1:0] lb_rd_addr_I;
  logic [LINE_BUF_ADDR_BITS-1:0] lb_rd_addr_II;
  logic [D_WIDTH-1:0]            lb_rd_data_I;
  logic [D_WIDTH-1:0]            lb_rd_data_II;
  logic [LINE_BUF_ADDR_BITS-1:0] lb_wr_addr_I;
  logic [LINE_BUF_ADDR_BITS-1:0] lb_wr_addr_II;
  logic [D_WIDTH-1:0]            lb_wr_data_I;
  logic [D_WIDTH-1:0]            lb_wr_data_II;
  logic                          lb_wr_en_I;
  logic                          lb_wr_en_II;
  logic                          out_valid;
  logic [D_WIDTH-1:0]            out_top;
  logic [D_WIDTH-1:0]            out_mid;
  logic [D_WIDTH-1:0]            out_bot;
  logic [LINE_BUF_ADDR_BITS-1:0] out_row;
  logic [LINE_BUF_ADDR_BITS-1:0] out_col;
  logic                          out_last;

  modport master (
    input  start, in_valid, in_data, lb_rd_data_I, lb_rd_data_II,
    output busy, in_ready,
    output lb_rd_addr_I, lb_rd_addr_II,
    output lb_wr_addr_I, lb_wr_addr_II, lb_wr_data_I, lb_wr_data_II,
    output lb_wr_en_I, lb_wr_en_II,
    output out_valid, out_top, out_mid, out_bot, out_row, out_col, out_last
  );

  modport slave (
    output start, in_valid, in_data, lb_rd_data_I, lb_rd_data_II,
    input  busy, in_ready,
    input  lb_rd_addr_I, lb_rd_addr_II,
    input  lb_wr_addr_I, lb_wr_addr_II, lb_wr_data_I, lb_wr_data_II,
    input  lb_wr_en_I, lb_wr_en_II,
    input  out_valid, out_top, out_mid, out_bot, out_row, out_col, out_last
  );

endinterface

// File: rtl/line_buffer_ctrl.sv
// Line-buffer group controller: zero-pads a row-major pixel stream, rotates
// rows through two line buffers and emits one top/mid/bot column per padded
// column for a 3x3 window shifter. Slot -> output latency is 2 cycles.
module line_buffer_ctrl #(
  parameter int unsigned IMG_W              = 28,
  parameter int unsigned IMG_H              = 28,
  parameter int unsigned D_WIDTH            = 16,
  parameter int unsigned LINE_BUF_ADDR_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  line_buffer_ctrl_if.master bus
);

  localparam int unsigned PW  = IMG_W + 2;
  localparam int unsigned PH  = IMG_H + 2;
  localparam int unsigned AW  = LINE_BUF_ADDR_BITS;
  localparam int unsigned PrW = $clog2(PH);

  localparam logic [AW-1:0]  PcLast = AW'(PW - 1);
  localparam logic [PrW-1:0] PrImgH = PrW'(IMG_H);
  localparam logic [PrW-1:0] PrLast = PrW'(PH - 1);
  localparam logic [PrW-1:0] PrTwo  = PrW'(2);

  typedef enum logic [1:0] {StIdle, StPadTop, StRow, StPadBot} state_e;

  state_e             state_q;
  logic [PrW-1:0]     pr_q;
  logic [AW-1:0]      pc_q;
  logic               sel_q;
  logic [AW-1:0]      rd_addr_q;
  logic               busy_q;

  logic               s1_valid_q;
  logic [D_WIDTH-1:0] s1_pix_q;
  logic [AW-1:0]      s1_pc_q;
  logic [PrW-1:0]     s1_pr_q;
  logic               s1_sel_q;

  logic               out_valid_q;
  logic               out_last_q;
  logic [D_WIDTH-1:0] out_top_q;
  logic [D_WIDTH-1:0] out_mid_q;
  logic [D_WIDTH-1:0] out_bot_q;
  logic [AW-1:0]      out_row_q;
  logic [AW-1:0]      out_col_q;

  logic               is_pad;
  logic               in_ready;
  logic               slot;
  logic [D_WIDTH-1:0] pixel;
  logic [AW-1:0]      rd_addr;

  // Slot decode: pad positions advance every cycle, real pixels only on a handshake.
  always_comb begin
    is_pad   = (state_q != StRow) || (pc_q == '0) || (pc_q == PcLast);
    in_ready = (state_q == StRow) && !is_pad;
    slot     = (state_q != StIdle) && (is_pad || bus.in_valid);
    pixel    = is_pad ? '0 : bus.in_data;
    // Both buffers are read at the slot's column; otherwise hold the last address.
    rd_addr  = slot ? pc_q : rd_addr_q;
  end

  // Frame FSM, padded position counters, buffer rotation and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pr_q      <= '0;
      pc_q      <= '0;
      sel_q     <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr;
      if (state_q == StIdle) begin
        if (bus.start) begin
          state_q <= StPadTop;
          pr_q    <= '0;
          pc_q    <= '0;
          sel_q   <= 1'b0;
        end
      end else if (slot) begin
        if (pc_q == PcLast) begin
          pc_q  <= '0;
          pr_q  <= pr_q + PrW'(1);
          sel_q <= ~sel_q;
          case (state_q)
            StPadTop: state_q <= StRow;
            StRow:    if (pr_q == PrImgH) state_q <= StPadBot;
            StPadBot: begin
              state_q <= StIdle;
              pr_q    <= '0;
              sel_q   <= 1'b0;
            end
            default:  state_q <= StIdle;
          endcase
        end else begin
          pc_q <= pc_q + AW'(1);
        end
      end
      // A new start wins over the end-of-frame clear.
      if (state_q == StIdle && bus.start) begin
        busy_q <= 1'b1;
      end else if (out_last_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Stage 1: capture the slot so its write and the read data line up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_pc_q    <= '0;
      s1_pr_q    <= '0;
      s1_sel_q   <= 1'b0;
    end else begin
      s1_valid_q <= slot;
      if (slot) begin
        s1_pix_q <= pixel;
        s1_pc_q  <= pc_q;
        s1_pr_q  <= pr_q;
        s1_sel_q <= sel_q;
      end
    end
  end

  // Output column register; rows 0 and 1 only fill the buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_top_q   <= '0;
      out_mid_q   <= '0;
      out_bot_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else if (s1_valid_q && (s1_pr_q >= PrTwo)) begin
      out_valid_q <= 1'b1;
      out_last_q  <= (s1_pr_q == PrLast) && (s1_pc_q == PcLast);
      out_top_q   <= s1_sel_q ? bus.lb_rd_data_II : bus.lb_rd_data_I;
      out_mid_q   <= s1_sel_q ? bus.lb_rd_data_I : bus.lb_rd_data_II;
      out_bot_q   <= s1_pix_q;
      out_row_q   <= AW'(s1_pr_q - PrTwo);
      out_col_q   <= s1_pc_q;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  // The stage-1 pixel overwrites the buffer holding row pr-2 (the oldest row).
  assign bus.lb_wr_en_I    = s1_valid_q && !s1_sel_q;
  assign bus.lb_wr_en_II   = s1_valid_q && s1_sel_q;
  assign bus.lb_wr_addr_I  = s1_pc_q;
  assign bus.lb_wr_addr_II = s1_pc_q;
  assign bus.lb_wr_data_I  = s1_pix_q;
  assign bus.lb_wr_data_II = s1_pix_q;

  assign bus.lb_rd_addr_I  = rd_addr;
  assign bus.lb_rd_addr_II = rd_addr;
  assign bus.in_ready      = in_ready;
  assign bus.busy          = busy_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_top   = out_top_q;
  assign bus.out_mid   = out_mid_q;
  assign bus.out_bot   = out_bot_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: models both line buffers, checks every
// emitted column and every buffer write against the padded-image formula.
module tb_line_buffer_ctrl;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PW    = IMG_W + 2;
  localparam int PH    = IMG_H + 2;
  localparam int NCOL  = IMG_H * PW;
  localparam int NWR   = PH * PW;

  logic clk;
  logic rst;

  line_buffer_ctrl_if #(.D_WIDTH(16), .LINE_BUF_ADDR_BITS(5)) bus ();

  line_buffer_ctrl #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .D_WIDTH(16),
    .LINE_BUF_ADDR_BITS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read line buffer models.
  logic [15:0] mem_i  [32];
  logic [15:0] mem_ii [32];
  always @(posedge clk) begin
    if (bus.lb_wr_en_I)  mem_i[bus.lb_wr_addr_I]   <= bus.lb_wr_data_I;
    if (bus.lb_wr_en_II) mem_ii[bus.lb_wr_addr_II] <= bus.lb_wr_data_II;
    bus.lb_rd_data_I  <= mem_i[bus.lb_rd_addr_I];
    bus.lb_rd_data_II <= mem_ii[bus.lb_rd_addr_II];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int n_out, n_last, wcount, pi;
  bit mon_en = 1'b0;
  int cap_top [NCOL];
  int cap_mid [NCOL];
  int cap_bot [NCOL];

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Padded image value: zero border, interior pixel = r*IMG_W + c + 1 (unpadded r,c).
  function automatic int pix(input int r, input int c);
    if (r == 0 || r == PH - 1 || c == 0 || c == PW - 1) return 0;
    return (r - 1) * IMG_W + c;
  endfunction

  // Output and write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("wr_en_exclusive", int'(bus.lb_wr_en_I) + int'(bus.lb_wr_en_II) <= 1 ? 1 : 0, 1);
      if (bus.lb_wr_en_I === 1'b1 || bus.lb_wr_en_II === 1'b1) begin
        int r, c;
        r = wcount / PW;
        c = wcount % PW;
        check("wr_buf_I", int'(bus.lb_wr_en_I), (r % 2 == 0) ? 1 : 0);
        check("wr_addr", bus.lb_wr_en_I ? int'(bus.lb_wr_addr_I) : int'(bus.lb_wr_addr_II), c);
        check("wr_data", bus.lb_wr_en_I ? int'(bus.lb_wr_data_I) : int'(bus.lb_wr_data_II),
              pix(r, c));
        wcount++;
      end
      if (bus.out_valid === 1'b1) begin
        int r, c;
        check("out_in_range", n_out < NCOL ? 1 : 0, 1);
        r = n_out / PW;
        c = n_out % PW;
        check("out_row", int'(bus.out_row), r);
        check("out_col", int'(bus.out_col), c);
        check("out_top", int'(bus.out_top), pix(r, c));
        check("out_mid", int'(bus.out_mid), pix(r + 1, c));
        check("out_bot", int'(bus.out_bot), pix(r + 2, c));
        check("out_last", int'(bus.out_last), (r == IMG_H - 1 && c == PW - 1) ? 1 : 0);
        if (n_out < NCOL) begin
          cap_top[n_out] = int'(bus.out_top);
          cap_mid[n_out] = int'(bus.out_mid);
          cap_bot[n_out] = int'(bus.out_bot);
        end
        if (bus.out_last === 1'b1) n_last++;
        n_out++;
      end else begin
        check("out_last_idle", int'(bus.out_last), 0);
      end
    end
  end

  task automatic check_reset_state();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_top", int'(bus.out_top), 0);
    check("rst_out_mid", int'(bus.out_mid), 0);
    check("rst_out_bot", int'(bus.out_bot), 0);
    check("rst_out_row", int'(bus.out_row), 0);
    check("rst_out_col", int'(bus.out_col), 0);
    check("rst_wr_en_I", int'(bus.lb_wr_en_I), 0);
    check("rst_wr_en_II", int'(bus.lb_wr_en_II), 0);
    check("rst_wr_addr", int'(bus.lb_wr_addr_I), 0);
    check("rst_wr_data", int'(bus.lb_wr_data_II), 0);
    check("rst_rd_addr", int'(bus.lb_rd_addr_I), 0);
  endtask

  // mode 0: continuous, 1: in_valid every other cycle, 2: stray start mid-frame,
  // 3: reset after 100 accepted pixels.
  task automatic run_frame(input int mode);
    int  cyc;
    bit  done, acc;
    n_out  = 0;
    n_last = 0;
    wcount = 0;
    pi     = 0;
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 5000) begin
      if (mode == 3 && pi == 100) begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        return;
      end
      bus.in_valid = (mode == 1) ? cyc[0] : 1'b1;
      bus.in_data  = bus.in_valid ? 16'(pi + 1) : 16'hdead;
      bus.start    = (mode == 2 && cyc == 300);
      @(negedge clk);
      if (cyc == 0) check("busy_after_start", int'(bus.busy), 1);
      acc = bus.in_valid && bus.in_ready;
      if (cyc > 0 && !bus.busy) done = 1'b1;
      if (!done) begin
        @(posedge clk);
        #1;
        if (acc) pi++;
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check("frame_done", int'(done), 1);
  endtask

  task automatic frame_checks();
    check("n_columns", n_out, NCOL);
    check("n_writes", wcount, NWR);
    check("n_last", n_last, 1);
    check("n_pixels", pi, IMG_W * IMG_H);
    check("busy_after", int'(bus.busy), 0);
    check("in_ready_after", int'(bus.in_ready), 0);
    check("c0_top", cap_top[0], 0);
    check("c0_mid", cap_mid[0], 0);
    check("c0_bot", cap_bot[0], 0);
    check("c1_bot", cap_bot[1], 29);
    check("c1_mid", cap_mid[1], 1);
    check("r27c28_top", cap_top[27 * PW + 28], 756);
    check("r27c28_mid", cap_mid[27 * PW + 28], 784);
    check("r27c28_bot", cap_bot[27 * PW + 28], 0);
    check("r26c1_top", cap_top[26 * PW + 1], 701);
    check("r26c1_mid", cap_mid[26 * PW + 1], 729);
    check("r26c1_bot", cap_bot[26 * PW + 1], 757);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    mon_en = 1'b1;

    @(posedge clk);
    #1;
    run_frame(0);
    frame_checks();

    run_frame(1);
    frame_checks();

    run_frame(3);
    run_frame(0);
    frame_checks();

    run_frame(2);
    frame_checks();
    // Back-to-back: start lands in the first cycle busy is low.
    run_frame(0);
    frame_checks();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
